// File: rtl/gpr_regfile.sv
// gpr_regfile: 32-entry MIPS GPR file, 2 async read ports, 1 sync write port.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding to reads.
module gpr_regfile #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 32,
  parameter int          SP_IDX   = 29,
  parameter logic [31:0] SP_INIT  = 32'h80120000,
  parameter int          RA_IDX   = 31,
  parameter logic [31:0] RA_INIT  = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd0_num,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [4:0]        rd1_num,
  output logic [DATA_W-1:0] rd1_data
);

  localparam logic [5:0] NREG = 6'(NUM_REGS);

  // reg 0 has no storage; it is the constant zero
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  logic wr_ok;
  assign wr_ok = wr_en && (wr_num != 5'd0) && ({1'b0, wr_num} < NREG);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i == SP_IDX)
          regs[i] <= DATA_W'(SP_INIT);
        else if (i == RA_IDX)
          regs[i] <= DATA_W'(RA_INIT);
        else
          regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_num] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0] num
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (num == 5'd0 || {1'b0, num} >= NREG)
      v = '0;
`ifdef REGFILE_BYPASS_EN
    else if (wr_ok && !reset && wr_num == num)
      v = wr_data;
`endif
    else
      v = regs[num];
    return v;
  endfunction

  assign rd0_data = read_port(rd0_num);
  assign rd1_data = read_port(rd1_num);

endmodule

// File: tb/tb_gpr_regfile.sv
// tb_gpr_regfile: directed plan checks plus randomized traffic
// compared against an array model of the register file.
module tb_gpr_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic [4:0]  rd0_num;
  logic [31:0] rd0_data;
  logic [4:0]  rd1_num;
  logic [31:0] rd1_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  gpr_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_num   (wr_num),
    .wr_data  (wr_data),
    .rd0_num  (rd0_num),
    .rd0_data (rd0_data),
    .rd1_num  (rd1_num),
    .rd1_data (rd1_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] n);
    if (n == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !reset && wr_num == n) return wr_data;
`endif
    return model[n];
  endfunction

  // apply what the edge just did to the model
  task automatic model_edge();
    if (reset) begin
      foreach (model[i]) model[i] = 32'h0;
      model[29] = 32'h80120000;
      model[31] = 32'h00000000;
    end else if (wr_en && wr_num != 0) begin
      model[wr_num] = wr_data;
    end
  endtask

  task automatic cycle(input logic r, input logic we,
                       input logic [4:0] wn,
                       input logic [31:0] wd,
                       input logic [4:0] r0,
                       input logic [4:0] r1);
    reset = r; wr_en = we; wr_num = wn; wr_data = wd;
    rd0_num = r0; rd1_num = r1;
    #1;
    check("rd0_pre", rd0_data, ref_rd(rd0_num));
    check("rd1_pre", rd1_data, ref_rd(rd1_num));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    reset = 1'b0; wr_en = 1'b0;
    rd0_num = r0; rd1_num = r1;
    #1;
  endtask

  initial begin
    logic [31:0] e;
    logic [4:0]  wn;
    logic        r, we;
    reset = 1'b1; wr_en = 1'b0; wr_num = '0; wr_data = '0;
    rd0_num = '0; rd1_num = '0;
    foreach (model[i]) model[i] = 32'h0;
    @(posedge clk);
    model_edge();
    #1;

    idle(5'd29, 5'd31);
    check("rst_sp", rd0_data, 32'h80120000);
    check("rst_ra", rd1_data, 32'h00000000);
    idle(5'd5, 5'd0);
    check("rst_r5", rd0_data, 32'h0);
    check("rst_r0", rd1_data, 32'h0);

    cycle(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8);
    idle(5'd8, 5'd8);
    check("wr8_p0", rd0_data, 32'hDEADBEEF);
    check("wr8_p1", rd1_data, 32'hDEADBEEF);
    idle(5'd29, 5'd7);
    check("wr8_sp", rd0_data, 32'h80120000);
    check("wr8_r7", rd1_data, 32'h0);

    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    check("r0_prot", rd0_data, 32'h0);

    cycle(1'b0, 1'b0, 5'd9, 32'h12345678, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    check("we_gate", rd0_data, 32'h0);

    cycle(1'b1, 1'b1, 5'd29, 32'h00001111, 5'd29, 5'd8);
    idle(5'd29, 5'd8);
    check("rst_prio", rd0_data, 32'h80120000);
    check("rst_clr8", rd1_data, 32'h0);

    cycle(1'b0, 1'b1, 5'd10, 32'hA, 5'd0, 5'd10);
    reset = 1'b0; wr_en = 1'b1; wr_num = 5'd10; wr_data = 32'hB;
    rd0_num = 5'd0; rd1_num = 5'd10;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_pre", rd1_data, 32'hB);
`else
    check("rdw_pre", rd1_data, 32'hA);
`endif
    @(posedge clk);
    model_edge();
    #1;
    idle(5'd0, 5'd10);
    check("rdw_post", rd1_data, 32'hB);

    for (int i = 1; i < 32; i++)
      cycle(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'd0);
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      e = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
      check("sweep_p0", rd0_data, e);
      e = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
      check("sweep_p1", rd1_data, e);
    end

    for (int k = 0; k < 2000; k++) begin
      r  = ($urandom_range(63) == 0);
      we = $urandom_range(1);
      wn = 5'($urandom_range(31));
      cycle(r, we, wn, $urandom,
            ($urandom_range(3) == 0) ? wn : 5'($urandom_range(31)),
            ($urandom_range(3) == 0) ? wn : 5'($urandom_range(31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
